// File: rtl/regfile_dump_reader.sv
// Debug read master for the CPU register file. It walks the registers two at a
// time through the combinational read ports and streams each word out on a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start, read addresses parked at 0
// READ   | pair 2p/2p+1 addressed, captured at the edge
// SEND_A | presenting register 2p
// SEND_B | presenting register 2p+1
// DONE   | one-cycle done pulse
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last
);

  localparam logic [ADDR_W-2:0] LAST_P = (ADDR_W-1)'(NUM_REGS/2 - 1);

  typedef enum logic [2:0] {IDLE, READ, SEND_A, SEND_B, DONE} state_t;

  state_t            state;
  logic [ADDR_W-2:0] p;
  logic [ADDR_W-2:0] p_inc;
  logic [DATA_W-1:0] buf_a;
  logic [DATA_W-1:0] buf_b;

  assign p_inc = p + 1'b1;

  // Both words come straight from the capture buffers, so they stay stable while stalled.
  assign out_data = (state == SEND_B) ? buf_b : buf_a;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      p         <= '0;
      buf_a     <= '0;
      buf_b     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      rf_ra1    <= '0;
      rf_ra2    <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        p         <= '0;
        busy      <= 1'b0;
        out_valid <= 1'b0;
        out_idx   <= '0;
        out_last  <= 1'b0;
        rf_ra1    <= '0;
        rf_ra2    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state  <= READ;
              p      <= '0;
              busy   <= 1'b1;
              rf_ra1 <= '0;
              rf_ra2 <= ADDR_W'(1);
            end
          end
          READ: begin
            buf_a     <= rf_rd1;
            buf_b     <= rf_rd2;
            out_valid <= 1'b1;
            out_idx   <= {p, 1'b0};
            out_last  <= 1'b0;
            state     <= SEND_A;
          end
          SEND_A: begin
            if (out_ready) begin
              out_idx  <= {p, 1'b1};
              out_last <= (p == LAST_P);
              state    <= SEND_B;
            end
          end
          SEND_B: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (p == LAST_P) begin
                state  <= DONE;
                done   <= 1'b1;
                rf_ra1 <= '0;
                rf_ra2 <= '0;
              end else begin
                // Address the next pair now so READ sees settled read data.
                p      <= p_inc;
                rf_ra1 <= {p_inc, 1'b0};
                rf_ra2 <= {p_inc, 1'b1};
                state  <= READ;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
            p     <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: a register-file array answers the read ports and
// every accepted beat is compared against the array contents in register order.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [4:0]  rf_ra1;
  logic [4:0]  rf_ra2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;

  logic [31:0] regs [0:31];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_ra1"}, rf_ra1, 0);
    check({tag, "_ra2"}, rf_ra2, 0);
  endtask

  // mode: 0 ready high, 1 random ready, 2 ready toggling. *_idx < 0 disables that event;
  // start_idx 32 means start is raised in the done cycle.
  task automatic dump(input int mode, input int stall_idx, input int start_idx,
                      input int abort_idx, input int rst_idx, input bit pattern);
    int exp_k = 0, dones = 0, busy_cyc = 0, stall_cnt = 0, cyc = 0;
    bit stalled = 0, prev_hold = 0, fin = 0, rdy = 1;
    logic [31:0] pd;
    logic [4:0]  pi;
    logic        pl;
    pd = '0; pi = '0; pl = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = pattern ? 32'(1001 + i) : $urandom;
    @(negedge clk);
    start = 1'b1;
    while (!fin && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (cyc == 1) begin
        check("lat_read_valid", out_valid, 0);
        check("lat_read_busy", busy, 1);
      end
      if (cyc == 2) check("lat_first_valid", out_valid, 1);
      if (busy) busy_cyc++;
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
        check("hold_idx", out_idx, pi);
        check("hold_last", out_last, pl);
      end
      if (!stalled && out_valid && int'(out_idx) == stall_idx) begin
        stalled = 1;
        stall_cnt = 5;
      end
      if (stall_cnt > 0) begin
        rdy = 0;
        stall_cnt--;
      end else if (mode == 1) rdy = $urandom_range(1, 0) == 1;
      else if (mode == 2) rdy = !rdy;
      else rdy = 1;
      out_ready = rdy;
      if (out_valid && int'(out_idx) == start_idx) start = 1'b1;
      if (done && start_idx == 32) start = 1'b1;

      if (rst_idx >= 0 && out_valid && int'(out_idx) == rst_idx) begin
        #2 n_rst = 1'b0;
        #1 check_all_zero("async_rst");
        start = 1'b0;
        @(negedge clk);
        check_all_zero("rst_held");
        n_rst = 1'b1;
        return;
      end
      if (abort_idx >= 0 && out_valid && int'(out_idx) == abort_idx && out_idx[0]) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        return;
      end

      if (done) begin
        dones++;
        check("done_after_last", exp_k, 32);
        check("done_busy", busy, 1);
        check("done_valid", out_valid, 0);
      end
      if (out_valid && rdy) begin
        check("beat_idx", out_idx, exp_k);
        check("beat_data", out_data, regs[exp_k]);
        check("beat_last", out_last, exp_k == 31);
        exp_k++;
      end
      prev_hold = out_valid && !rdy;
      pd = out_data;
      pi = out_idx;
      pl = out_last;
      if (dones > 0 && !busy) fin = 1;
    end
    out_ready = 1'b1;
    start = 1'b0;
    check("dump_timeout", fin, 1);
    check("beat_count", exp_k, 32);
    check("done_count", dones, 1);
    if (mode == 0 && stall_idx < 0) check("busy_cycles", busy_cyc, 49);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_after", busy, 0);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    start = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    dump(0, -1, -1, -1, -1, 1);
    dump(2, 6, -1, -1, -1, 1);
    dump(1, -1, 10, -1, -1, 0);
    dump(0, -1, 32, -1, -1, 0);
    dump(0, -1, -1, 13, -1, 0);
    dump(1, -1, -1, -1, -1, 0);
    dump(0, -1, -1, 31, -1, 0);
    dump(0, -1, -1, -1, 20, 0);
    dump(1, -1, -1, -1, -1, 0);
    dump(2, 17, -1, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
